// File: rtl/jam_cost_if.sv
// jam_cost_if: load stream, query and status signals between a JAM engine and its cost server.
interface jam_cost_if #(
  parameter int COST_W = 7,
  parameter int QCNT_W = 16
);
  logic              load_valid;
  logic [COST_W-1:0] load_data;
  logic              load_ready;
  logic              reload;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [COST_W-1:0] Cost;
  logic              Ready;
  logic [9:0]        LowerBound;
  logic [QCNT_W-1:0] QueryCount;
  modport master (
    output load_valid, load_data, reload, W, J,
    input  load_ready, Cost, Ready, LowerBound, QueryCount
  );
  modport slave (
    input  load_valid, load_data, reload, W, J,
    output load_ready, Cost, Ready, LowerBound, QueryCount
  );
endinterface

// File: rtl/jam_cost_server.sv
// jam_cost_server: 8x8 cost table with streaming load, row-minimum lower bound and query counting.
module jam_cost_server #(
  parameter int N_DIM  = 8,
  parameter int COST_W = 7,
  parameter int QCNT_W = 16
) (
  input  logic       CLK,
  input  logic       RST,
  jam_cost_if.slave  bus
);
  typedef enum logic {LOAD, READY} state_t;
  state_t            state_q, state_d;
  logic [COST_W-1:0] table_q [N_DIM*N_DIM];
  logic [5:0]        idx_q, idx_d;
  logic [COST_W-1:0] row_min_q, row_min_d;
  logic [9:0]        bound_q, bound_d;
  logic [QCNT_W-1:0] qcnt_q, qcnt_d;
  logic [5:0]        prev_q, prev_d;
  logic              accept;
  logic [2:0]        col;
  logic [COST_W-1:0] rmin_new;
  logic [5:0]        qry;
  assign accept   = state_q == LOAD && bus.load_valid && !bus.reload;
  assign col      = idx_q[2:0];
  assign rmin_new = (col == 3'd0 || bus.load_data < row_min_q) ? bus.load_data : row_min_q;
  assign qry      = {bus.W, bus.J};
  assign bus.load_ready = state_q == LOAD;
  assign bus.Ready      = state_q == READY;
  assign bus.LowerBound = state_q == READY ? bound_q : '0;
  assign bus.QueryCount = qcnt_q;
  assign bus.Cost       = table_q[qry];
  always_comb begin
    state_d   = bus.reload ? LOAD : (accept && idx_q == 6'd63) ? READY : state_q;
    idx_d     = bus.reload ? '0 : accept ? idx_q + 6'd1 : idx_q;
    row_min_d = bus.reload ? '0 : accept ? rmin_new : row_min_q;
    bound_d   = bus.reload ? '0 : (accept && col == 3'd7) ? bound_q + 10'(rmin_new) : bound_q;
    prev_d    = (state_q == READY && !bus.reload) ? qry : '0;
    qcnt_d    = bus.reload ? '0 :
                (state_q == READY && qry != prev_q && qcnt_q != '1) ? qcnt_q + QCNT_W'(1) : qcnt_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      row_min_q <= '0;
      bound_q   <= '0;
      qcnt_q    <= '0;
      prev_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      row_min_q <= row_min_d;
      bound_q   <= bound_d;
      qcnt_q    <= qcnt_d;
      prev_q    <= prev_d;
    end
  end
  // Table contents survive reload; only RST clears them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_DIM*N_DIM; i++) table_q[i] <= '0;
    end else if (accept) begin
      table_q[idx_q] <= bus.load_data;
    end
  end
endmodule

// File: tb/tb_jam_cost_server.sv
// tb_jam_cost_server: directed and randomized checks of table load, bound and query counting.
module tb_jam_cost_server;
  logic CLK = 0;
  logic RST = 1;
  int total = 0;
  int bad = 0;
  logic [6:0] tbl [64];
  int mcnt;
  logic [5:0] mprev;
  jam_cost_if bus ();
  jam_cost_server dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lb_model();
    int s = 0;
    for (int w = 0; w < 8; w++) begin
      int m = 127;
      for (int j = 0; j < 8; j++) if (int'(tbl[w*8+j]) < m) m = int'(tbl[w*8+j]);
      s += m;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // mode 0: continuous, 1: alternating bubbles, 2: random bubbles
  task automatic load(input int n, input int mode);
    int k = 0;
    int cyc = 0;
    logic rdy;
    while (k < n && cyc < 1000) begin
      bus.load_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      bus.load_data  = tbl[k];
      rdy = bus.load_ready;
      if (k < 64 && bus.load_valid) chk("ready_before_done", {31'b0, bus.Ready}, 0);
      tick();
      if (bus.load_valid && rdy) k++;
      cyc++;
    end
    bus.load_valid = 0;
    if (k != n) chk("load_timeout", k, n);
    if (n == 64) begin
      chk("load_ready_drop", {31'b0, bus.load_ready}, 0);
      chk("ready_rise", {31'b0, bus.Ready}, 1);
      chk("lower_bound", {22'b0, bus.LowerBound}, lb_model());
    end
  endtask

  task automatic do_reload();
    bus.reload = 1;
    bus.load_valid = 1;
    bus.load_data = 7'h7f;
    tick();
    bus.reload = 0;
    bus.load_valid = 0;
    chk("reload_ready", {31'b0, bus.Ready}, 0);
    chk("reload_lb", {22'b0, bus.LowerBound}, 0);
    chk("reload_qc", {16'b0, bus.QueryCount}, 0);
    chk("reload_load_ready", {31'b0, bus.load_ready}, 1);
  endtask

  task automatic query(input int w, input int j);
    bus.W = 3'(w);
    bus.J = 3'(j);
    #1;
    chk("cost_same_cycle", {25'b0, bus.Cost}, {25'b0, tbl[w*8+j]});
    if ({3'(w), 3'(j)} != mprev) mcnt++;
    mprev = {3'(w), 3'(j)};
    tick();
    chk("query_count", {16'b0, bus.QueryCount}, mcnt);
  endtask

  initial begin
    bus.load_valid = 0;
    bus.load_data = 0;
    bus.reload = 0;
    bus.W = 0;
    bus.J = 0;
    #12 RST = 0;
    #1;
    chk("rst_load_ready", {31'b0, bus.load_ready}, 1);
    chk("rst_ready", {31'b0, bus.Ready}, 0);
    chk("rst_lb", {22'b0, bus.LowerBound}, 0);
    chk("rst_qc", {16'b0, bus.QueryCount}, 0);
    chk("rst_cost", {25'b0, bus.Cost}, 0);
    @(negedge CLK);
    tick();

    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) tbl[w*8+j] = 7'(10*w + j + 1);
    load(64, 0);
    chk("lb_288", {22'b0, bus.LowerBound}, 288);
    bus.W = 3; bus.J = 5; #1;
    chk("cost_3_5", {25'b0, bus.Cost}, 36);
    bus.W = 7; bus.J = 7; #1;
    chk("cost_7_7", {25'b0, bus.Cost}, 78);
    bus.W = 0; bus.J = 0;
    tick();

    do_reload();
    load(64, 1);
    chk("lb_288_bubbles", {22'b0, bus.LowerBound}, 288);
    for (int i = 0; i < 64; i++) begin
      bus.W = 3'(i / 8); bus.J = 3'(i % 8); #1;
      chk("cost_bubbles", {25'b0, bus.Cost}, {25'b0, tbl[i]});
    end
    bus.W = 0; bus.J = 0;
    tick();

    do_reload();
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) tbl[w*8+j] = (w == j) ? 7'(w + 2) : 7'd127;
    load(64, 2);
    chk("lb_44", {22'b0, bus.LowerBound}, 44);

    do_reload();
    for (int i = 0; i < 64; i++) tbl[i] = 7'(3 + i % 50);
    load(30, 0);
    do_reload();
    for (int i = 0; i < 64; i++) tbl[i] = 7'd5;
    load(64, 0);
    chk("lb_40", {22'b0, bus.LowerBound}, 40);
    for (int i = 0; i < 64; i += 9) begin
      bus.W = 3'(i / 8); bus.J = 3'(i % 8); #1;
      chk("cost_5", {25'b0, bus.Cost}, 5);
    end
    bus.W = 0; bus.J = 0;
    tick();

    do_reload();
    load(64, 0);
    mcnt = 0; mprev = 0;
    query(0, 0); query(0, 0); query(1, 2); query(1, 2); query(4, 4);
    chk("qc_2", {16'b0, bus.QueryCount}, 2);

    for (int r = 0; r < 4; r++) begin
      bus.W = 0; bus.J = 0;
      do_reload();
      for (int i = 0; i < 64; i++) tbl[i] = 7'($urandom_range(0, 127));
      load(64, 2);
      mcnt = 0; mprev = 0;
      for (int q = 0; q < 30; q++) begin
        if ($urandom_range(0, 1) == 1) query(int'(mprev[5:3]), int'(mprev[2:0]));
        else query(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
    end

    #2 RST = 1;
    #1;
    chk("arst_ready", {31'b0, bus.Ready}, 0);
    chk("arst_qc", {16'b0, bus.QueryCount}, 0);
    chk("arst_lb", {22'b0, bus.LowerBound}, 0);
    bus.W = 3; bus.J = 5; #1;
    chk("arst_cost", {25'b0, bus.Cost}, 0);
    #3 RST = 0;
    tick();
    chk("arst_load_ready", {31'b0, bus.load_ready}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
Responder side of the JAM worker/job cost interface. It holds the 8x8 table of 7-bit worker-to-job costs and answers every (W, J) query with Cost in the same cycle, so an exhaustive-search JAM engine can sample Cost on the clock edge after it drives W/J. The table is loaded over a streaming valid/ready port. During the load the block also computes the sum of row minima, which is a lower bound on any assignment cost. In READY it counts distinct queries for performance checks.

Parameters:
N_DIM, 8, workers = jobs; fixed at 8 (index width 3, 64 entries)
COST_W, 7, cost entry width
QCNT_W, 16, query counter width

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
load_valid  input  1  load_data holds a valid table entry
load_data  input  7  cost entry, row-major order (worker-major, job-minor)
load_ready  output  1  block accepts an entry this cycle
reload  input  1  single-cycle pulse; restart table load
W  input  3  queried worker index
J  input  3  queried job index
Cost  output  7  table[W][J], combinational
Ready  output  1  table fully loaded
LowerBound  output  10  sum over rows of min_j table[w][j]
QueryCount  output  16  distinct queries observed in READY, saturating

Behaviour:
- Reset values: state=LOAD, all 64 table entries=0, idx=0, row_min=0, bound_acc=0, Ready=0, LowerBound=0, QueryCount=0, prev_q=0. load_ready=1 immediately after reset deasserts.
- Cost = table[{W,J}] in every state, with no clock latency. During LOAD, entries not yet written read as 0, or as the previous load's value after a reload.
- FSM:
  - LOAD: load_ready=1. An entry is accepted when load_valid&&load_ready. Each accept writes table[idx], where row=idx[5:3] and col=idx[2:0], then idx++. Bubbles (load_valid=0) are allowed at any point and hold all state.
  - LOAD, row minimum: an accept with col==0 sets row_min<=load_data; an accept with col!=0 sets row_min<=min(row_min, load_data).
  - LOAD, bound: an accept with col==7 sets bound_acc<=bound_acc+min(row_min, load_data). Bound arithmetic is 10-bit; the maximum value is 8*127=1016, so no overflow.
  - LOAD -> READY on the 64th accept (idx==63). In READY on the next cycle: Ready=1, LowerBound=final bound_acc.
  - READY: load_ready=0 and load_valid is ignored. QueryCount increments when {W,J}!=prev_q. prev_q<={W,J} every READY cycle. On the first READY cycle prev_q is compared as loaded with {0,0}. QueryCount saturates at 65535.
- reload (any state, highest priority after RST): next cycle state=LOAD, idx=0, bound_acc=0, row_min=0, Ready=0, LowerBound=0, QueryCount=0. Table contents are retained until overwritten. An accept in the same cycle as reload is discarded.
- reload during LOAD restarts at idx 0; partial row minima are discarded.
- RST asserted mid-load or mid-query: all state returns to reset values immediately (asynchronous), including the table contents.
- No X on any output; W/J are always in range (3 bits).

Test Plan:
- Continuous load of cost(w,j)=10*w+j+1, 64 consecutive cycles with load_valid=1 -> load_ready drops after the 64th accept; Ready=1 one cycle later; LowerBound=288; Cost(W=3,J=5)=36 and Cost(7,7)=78 in the same cycle W/J are applied.
- Same table with load_valid toggling 1,0,1,0 -> identical table contents and LowerBound=288; Ready rises one cycle after the 64th accept, not after the 64th cycle.
- Row minima at varied columns: row w holds 127 except entry (w, w)=w+2 -> LowerBound=sum(w+2 for w=0..7)=44.
- reload pulse after 30 accepts, then a full 64-entry load of all-5 -> LowerBound=40, Ready=1, every Cost=5.
- In READY, drive (W,J) sequence (0,0),(0,0),(1,2),(1,2),(4,4) over 5 cycles -> QueryCount=2; then RST mid-READY -> Ready=0, QueryCount=0, LowerBound=0, Cost=0.
- JAM pairing: connect to the JAM engine with a loaded table -> the engine's MinCost and MatchCount match a software brute-force search over all 40320 permutations.
